// File: rtl/ev22_pkg.sv
// EV22 memory/writeback shared definitions.
// Default widths, register indices and sequencer state encodings.
package ev22_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 6;
  localparam int ADDR_W   = 12;
  localparam int W_REG    = 34;
  localparam int NULL_REG = 35;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t RD_WAIT = 2'd1;
  localparam state_t WR_WAIT = 2'd2;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for outstanding data-memory accesses.
// expired is high on the last wait cycle the access may still see an ack.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Count wait cycles without ack, restarting on each new access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_wb_ctrl.sv
// EV22 memory/writeback sequencer (data memory + register-file port).
// Build option PERF_CNT_EN adds the perf_stall counter output.
module mem_wb_ctrl #(
  parameter int DATA_W   = ev22_pkg::DATA_W,
  parameter int SEL_W    = ev22_pkg::SEL_W,
  parameter int ADDR_W   = ev22_pkg::ADDR_W,
  parameter int W_REG    = ev22_pkg::W_REG,
  parameter int NULL_REG = ev22_pkg::NULL_REG,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mr,
  input  logic              in_mw,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_w,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_sel,
  output logic [DATA_W-1:0] rf_data,
  output logic              err
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall
`endif
);

  import ev22_pkg::*;

  state_t state;
  logic   accept;
  logic   mem_start;
  logic   waiting;
  logic   expired;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign mem_start = accept & (in_mr ^ in_mw);
  assign waiting   = (state != IDLE);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (mem_start),
    .en      (waiting & ~mem_ack),
    .expired (expired)
  );

  // Sequencer: issue accesses, complete or abort them, drive the rf port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_sel    <= SEL_W'(NULL_REG);
      rf_data   <= '0;
      err       <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_mr && in_mw) begin
              err <= 1'b1;
            end else if (in_mr) begin
              mem_addr <= in_addr;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              state    <= RD_WAIT;
            end else if (in_mw) begin
              mem_addr  <= in_addr;
              mem_wdata <= in_w;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= WR_WAIT;
            end else begin
              rf_we   <= (in_sel != SEL_W'(NULL_REG));
              rf_sel  <= in_sel;
              rf_data <= in_data;
            end
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rf_we   <= 1'b1;
            rf_sel  <= SEL_W'(W_REG);
            rf_data <= mem_rdata;
            state   <= IDLE;
          end else if (expired) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (expired) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Saturating count of cycles where execute is held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
    end else if (in_valid && !in_ready && perf_stall != 16'hFFFF) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
